// File: rtl/mux_vc_arbiter_pkg.sv
// Shared definitions for the VC merge path: VC identifiers, default sizing
// and the grant encoding passed from the grant logic to the output stage.
package mux_vc_arbiter_pkg;

   localparam logic VC0_ID = 1'b0;
   localparam logic VC1_ID = 1'b1;

   localparam int DEFAULT_DATA_SIZE  = 6;
   localparam int DEFAULT_WEIGHT_VC0 = 4;
   localparam int DEFAULT_CNT_W      = 3;

   typedef enum logic [1:0] {
      GRANT_NONE = 2'd0,
      GRANT_VC0  = 2'd1,
      GRANT_VC1  = 2'd2
   } grant_e;

endpackage

// File: rtl/mux_vc_arbiter_if.sv
// Handshake bundle between the two VC FIFOs, the merge arbiter and the
// downstream stage. master = arbiter side, slave = FIFO/downstream side.
interface mux_vc_arbiter_if
   import mux_vc_arbiter_pkg::*;
#(
   parameter int DATA_SIZE = DEFAULT_DATA_SIZE
);

   logic                 vc0_empty;
   logic                 vc1_empty;
   logic [DATA_SIZE-1:0] data_vc0;
   logic [DATA_SIZE-1:0] data_vc1;
   logic                 out_full;
   logic                 pop_vc0;
   logic                 pop_vc1;
   logic [DATA_SIZE-1:0] data_out;
   logic                 valid_out;
   logic                 vc_out;

   modport master (
      input  vc0_empty, vc1_empty, data_vc0, data_vc1, out_full,
      output pop_vc0, pop_vc1, data_out, valid_out, vc_out
   );

   modport slave (
      output vc0_empty, vc1_empty, data_vc0, data_vc1, out_full,
      input  pop_vc0, pop_vc1, data_out, valid_out, vc_out
   );

endinterface

// File: rtl/mux_vc_arbiter_vc_grant_logic.sv
// Weighted-priority grant between VC0 and VC1. VC0 is favoured, but after
// WEIGHT_VC0-1 consecutive VC0 grants with VC1 waiting, VC1 gets one slot.
// The burst counter saturates rather than wraps, so a VC1 that shows up
// after a long VC0-only run is served on its first cycle.
module vc_grant_logic
   import mux_vc_arbiter_pkg::*;
#(
   parameter int WEIGHT_VC0 = DEFAULT_WEIGHT_VC0,
   parameter int CNT_W      = DEFAULT_CNT_W
) (
   input  logic   clk,
   input  logic   reset,
   input  logic   enable,
   input  logic   vc0_empty,
   input  logic   vc1_empty,
   output grant_e grant
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WEIGHT_VC0 - 1);

   logic [CNT_W-1:0] burst_cnt;

   // Grant from the empties sampled this cycle; enable carries reset and backpressure.
   always_comb begin
      grant = GRANT_NONE;
      if (enable) begin
         case ({vc0_empty, vc1_empty})
            2'b00:   grant = (burst_cnt == CNT_MAX) ? GRANT_VC1 : GRANT_VC0;
            2'b01:   grant = GRANT_VC0;
            2'b10:   grant = GRANT_VC1;
            default: grant = GRANT_NONE;
         endcase
      end
   end

   // Count VC0 grants, cleared by a VC1 grant, held when nothing is granted.
   always_ff @(posedge clk) begin
      if (reset) begin
         burst_cnt <= '0;
      end else begin
         case (grant)
            GRANT_VC1: burst_cnt <= '0;
            GRANT_VC0: if (burst_cnt != CNT_MAX) burst_cnt <= burst_cnt + CNT_W'(1);
            default:   burst_cnt <= burst_cnt;
         endcase
      end
   end

endmodule

// File: rtl/mux_vc_arbiter.sv
// Merges the VC0 and VC1 show-ahead FIFOs into one registered word stream
// with a source-VC tag. Pops are combinational; the merged word appears on
// the cycle after its pop. Reset and out_full both suppress all pops.
module mux_vc_arbiter
   import mux_vc_arbiter_pkg::*;
#(
   parameter int DATA_SIZE  = DEFAULT_DATA_SIZE,
   parameter int WEIGHT_VC0 = DEFAULT_WEIGHT_VC0,
   parameter int CNT_W      = DEFAULT_CNT_W
) (
   input  logic               clk,
   input  logic               reset,
   mux_vc_arbiter_if.master   bus
);

   grant_e               grant;
   logic                 enable;
   logic [DATA_SIZE-1:0] head_word;

   assign enable = !reset && !bus.out_full;

   vc_grant_logic #(
      .WEIGHT_VC0 (WEIGHT_VC0),
      .CNT_W      (CNT_W)
   ) u_grant (
      .clk       (clk),
      .reset     (reset),
      .enable    (enable),
      .vc0_empty (bus.vc0_empty),
      .vc1_empty (bus.vc1_empty),
      .grant     (grant)
   );

   assign bus.pop_vc0 = (grant == GRANT_VC0);
   assign bus.pop_vc1 = (grant == GRANT_VC1);
   assign head_word   = (grant == GRANT_VC1) ? bus.data_vc1 : bus.data_vc0;

   // Output register: capture the granted head word; otherwise drop valid and hold data/tag.
   always_ff @(posedge clk) begin
      if (reset) begin
         bus.data_out  <= '0;
         bus.valid_out <= 1'b0;
         bus.vc_out    <= VC0_ID;
      end else if (grant != GRANT_NONE) begin
         bus.data_out  <= head_word;
         bus.valid_out <= 1'b1;
         bus.vc_out    <= (grant == GRANT_VC1) ? VC1_ID : VC0_ID;
      end else begin
         bus.valid_out <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mux_vc_arbiter.sv
// Bench for mux_vc_arbiter: FIFO models as queues, a reference grant model,
// and a scoreboard of {vc, word} pushed at grant time and popped on valid_out.
module tb_mux_vc_arbiter;
   import mux_vc_arbiter_pkg::*;

   localparam int DW = 6;
   localparam int W  = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic full = 1'b0;

   int checks = 0;
   int errors = 0;
   int pops_total = 0;
   int words_total = 0;
   int mcnt = 0;

   logic [DW-1:0] q0[$];
   logic [DW-1:0] q1[$];
   logic [DW:0]   sb[$];

   logic p0, p1, eg0, eg1, ov, ovc;
   logic [DW-1:0] od;

   always #5 clk = ~clk;

   mux_vc_arbiter_if #(.DATA_SIZE(DW)) bus ();

   mux_vc_arbiter #(.DATA_SIZE(DW), .WEIGHT_VC0(W), .CNT_W(3)) dut (
      .clk   (clk),
      .reset (rst),
      .bus   (bus)
   );

   // One clock cycle, starting and ending at the falling edge. Drives the FIFO
   // heads, computes the reference grant, records pops before the edge and
   // the registered outputs just after it.
   task automatic tick();
      bus.vc0_empty = (q0.size() == 0);
      bus.vc1_empty = (q1.size() == 0);
      bus.data_vc0  = (q0.size() != 0) ? q0[0] : '0;
      bus.data_vc1  = (q1.size() != 0) ? q1[0] : '0;
      bus.out_full  = full;
      eg0 = 1'b0;
      eg1 = 1'b0;
      if (!rst && !full) begin
         if (q0.size() != 0 && q1.size() != 0) begin
            if (mcnt == W - 1) eg1 = 1'b1;
            else               eg0 = 1'b1;
         end else if (q0.size() != 0) eg0 = 1'b1;
         else if (q1.size() != 0)     eg1 = 1'b1;
      end
      if (eg0) sb.push_back({1'b0, q0[0]});
      if (eg1) sb.push_back({1'b1, q1[0]});
      #1;
      p0 = bus.pop_vc0;
      p1 = bus.pop_vc1;
      @(posedge clk);
      #1;
      if (p0 === 1'b1 && q0.size() != 0) void'(q0.pop_front());
      if (p1 === 1'b1 && q1.size() != 0) void'(q1.pop_front());
      if (p0 === 1'b1 || p1 === 1'b1) pops_total++;
      if (rst)                          mcnt = 0;
      else if (eg1)                     mcnt = 0;
      else if (eg0 && mcnt < W - 1)     mcnt++;
      ov  = bus.valid_out;
      ovc = bus.vc_out;
      od  = bus.data_out;
      if (ov === 1'b1) words_total++;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      q0 = '{6'h01, 6'h02};
      q1 = '{6'h03};
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++;
         if ({p0, p1} !== 2'b00) begin
            errors++; $display("FAIL reset_pops: got %b expected 00", {p0, p1});
         end
         checks++;
         if (ov !== 1'b0) begin
            errors++; $display("FAIL reset_valid: got %b expected 0", ov);
         end
         checks++;
         if (od !== 6'h00) begin
            errors++; $display("FAIL reset_data: got %h expected 00", od);
         end
      end
      q0.delete();
      q1.delete();
      rst = 1'b0;
   endtask

   task automatic test_vc1_only();
      logic [DW:0] e;
      logic [DW-1:0] want [2];
      want[0] = 6'h2A;
      want[1] = 6'h2B;
      q1 = '{6'h2A, 6'h2B};
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if ({p0, p1} !== {1'b0, (i < 2)}) begin
            errors++; $display("FAIL vc1only_pops[%0d]: got %b expected %b", i, {p0, p1}, {1'b0, (i < 2)});
         end
         checks++;
         if (ov !== (i < 2)) begin
            errors++; $display("FAIL vc1only_valid[%0d]: got %b expected %b", i, ov, (i < 2));
         end
         if (i < 2) begin
            checks++;
            if ({ovc, od} !== {1'b1, want[i]}) begin
               errors++; $display("FAIL vc1only_word[%0d]: got %b/%h expected 1/%h", i, ovc, od, want[i]);
            end
         end
         if (ov === 1'b1 && sb.size() != 0) e = sb.pop_front();
      end
   endtask

   task automatic test_weighted();
      logic [DW:0] e;
      int n = 0;
      rst = 1'b1; tick(); rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         q0.push_back(DW'(i));
         q1.push_back(DW'(6'h20 + i));
      end
      for (int t = 0; t < 30 && (q0.size() != 0 || q1.size() != 0); t++) begin
         tick();
         checks++;
         if ({p0, p1} !== {eg0, eg1}) begin
            errors++; $display("FAIL weighted_pops[%0d]: got %b expected %b", t, {p0, p1}, {eg0, eg1});
         end
         if (n < 8) begin
            checks++;
            if (p1 !== (n % 4 == 3)) begin
               errors++; $display("FAIL weighted_order[%0d]: got vc1=%b expected %b", n, p1, (n % 4 == 3));
            end
         end
         if (p1 === 1'b1) begin
            checks++;
            if (dut.u_grant.burst_cnt !== 3'd0) begin
               errors++; $display("FAIL weighted_cnt_clear: got %0d expected 0", dut.u_grant.burst_cnt);
            end
         end
         checks++;
         if (ov !== (eg0 | eg1)) begin
            errors++; $display("FAIL weighted_valid[%0d]: got %b expected %b", t, ov, eg0 | eg1);
         end
         if (ov === 1'b1 && sb.size() != 0) begin
            e = sb.pop_front();
            checks++;
            if ({ovc, od} !== e) begin
               errors++; $display("FAIL weighted_word[%0d]: got %h expected %h", t, {ovc, od}, e);
            end
         end
         n++;
      end
      checks++;
      if (q0.size() != 0 || q1.size() != 0) begin
         errors++; $display("FAIL weighted_timeout: left %0d/%0d expected 0/0", q0.size(), q1.size());
      end
   endtask

   task automatic test_backpressure();
      logic [DW:0] e;
      int out0 = words_total;
      for (int i = 0; i < 8; i++) q0.push_back(DW'(6'h10 + i));
      for (int t = 0; t < 12; t++) begin
         full = (t >= 3 && t < 6);
         tick();
         if (full) begin
            checks++;
            if ({p0, p1} !== 2'b00) begin
               errors++; $display("FAIL bp_blocked[%0d]: got %b expected 00", t, {p0, p1});
            end
         end
         checks++;
         if ({p0, p1} !== {eg0, eg1}) begin
            errors++; $display("FAIL bp_pops[%0d]: got %b expected %b", t, {p0, p1}, {eg0, eg1});
         end
         checks++;
         if (ov !== (eg0 | eg1)) begin
            errors++; $display("FAIL bp_valid[%0d]: got %b expected %b", t, ov, eg0 | eg1);
         end
         if (ov === 1'b1 && sb.size() != 0) begin
            e = sb.pop_front();
            checks++;
            if ({ovc, od} !== e) begin
               errors++; $display("FAIL bp_word[%0d]: got %h expected %h", t, {ovc, od}, e);
            end
         end
      end
      full = 1'b0;
      checks++;
      if (words_total - out0 != 8 || q0.size() != 0) begin
         errors++; $display("FAIL bp_count: got %0d words expected 8", words_total - out0);
      end
   endtask

   task automatic test_saturate();
      logic [DW:0] e;
      rst = 1'b1; tick(); rst = 1'b0;
      for (int i = 0; i < 12; i++) q0.push_back(DW'(6'h30 + i));
      for (int t = 0; t < 14; t++) begin
         if (t == 8) q1.push_back(6'h15);
         tick();
         if (t == 7) begin
            checks++;
            if (dut.u_grant.burst_cnt !== 3'd3) begin
               errors++; $display("FAIL sat_cnt: got %0d expected 3", dut.u_grant.burst_cnt);
            end
         end
         if (t == 8) begin
            checks++;
            if ({p0, p1} !== 2'b01) begin
               errors++; $display("FAIL sat_vc1_next: got %b expected 01", {p0, p1});
            end
         end
         checks++;
         if (ov !== (eg0 | eg1)) begin
            errors++; $display("FAIL sat_valid[%0d]: got %b expected %b", t, ov, eg0 | eg1);
         end
         if (ov === 1'b1 && sb.size() != 0) begin
            e = sb.pop_front();
            checks++;
            if ({ovc, od} !== e) begin
               errors++; $display("FAIL sat_word[%0d]: got %h expected %h", t, {ovc, od}, e);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [DW:0] e;
      for (int i = 0; i < 6; i++) begin
         q0.push_back(DW'(6'h08 + i));
         q1.push_back(DW'(6'h38 + i));
      end
      for (int t = 0; t < 25 && (q0.size() != 0 || q1.size() != 0 || t < 5); t++) begin
         rst = (t == 3);
         tick();
         if (t == 2) begin
            checks++;
            if (ov !== 1'b1) begin
               errors++; $display("FAIL midrst_pre_valid: got %b expected 1", ov);
            end
         end
         if (t == 3) begin
            checks++;
            if ({p0, p1, ov} !== 3'b000) begin
               errors++; $display("FAIL midrst_edge: got pops/valid %b expected 000", {p0, p1, ov});
            end
         end
         if (t == 4) begin
            checks++;
            if ({p0, p1} !== 2'b10) begin
               errors++; $display("FAIL midrst_resume: got %b expected 10", {p0, p1});
            end
         end
         checks++;
         if ({p0, p1} !== {eg0, eg1}) begin
            errors++; $display("FAIL midrst_pops[%0d]: got %b expected %b", t, {p0, p1}, {eg0, eg1});
         end
         if (ov === 1'b1 && sb.size() != 0) begin
            e = sb.pop_front();
            checks++;
            if ({ovc, od} !== e) begin
               errors++; $display("FAIL midrst_word[%0d]: got %h expected %h", t, {ovc, od}, e);
            end
         end
      end
      rst = 1'b0;
      checks++;
      if (q0.size() != 0 || q1.size() != 0) begin
         errors++; $display("FAIL midrst_timeout: left %0d/%0d expected 0/0", q0.size(), q1.size());
      end
   endtask

   initial begin
      bus.vc0_empty = 1'b1;
      bus.vc1_empty = 1'b1;
      bus.data_vc0  = '0;
      bus.data_vc1  = '0;
      bus.out_full  = 1'b0;
      @(negedge clk);
      test_reset();
      test_vc1_only();
      test_weighted();
      test_backpressure();
      test_saturate();
      test_reset_mid();
      checks++;
      if (words_total != pops_total || sb.size() != 0) begin
         errors++;
         $display("FAIL totals: got %0d words, %0d pending expected %0d words, 0 pending",
                  words_total, sb.size(), pops_total);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
